// File: rtl/bool_lut_eval_if.sv
// Bus bundle for bool_lut_eval: truth-table load, single-vector evaluate,
// and exhaustive-sweep control/status.
//   master modport : requester side (drives cfg/in/sweep requests)
//   slave modport  : evaluator side (drives ready, result and sweep status)
// Optional macro BOOL_LUT_SIGNATURE_EN adds the 16-bit sweep signature 'sig'.
interface bool_lut_eval_if #(
    parameter int unsigned N_IN = 4
);
    localparam int unsigned TT_W  = 1 << N_IN;
    localparam int unsigned CNT_W = N_IN + 1;

    logic             cfg_valid;
    logic [TT_W-1:0]  cfg_data;
    logic             cfg_ready;
    logic             in_valid;
    logic [N_IN-1:0]  in_vec;
    logic             in_ready;
    logic             y_valid;
    logic             y;
    logic             sweep_start;
    logic             sweep_busy;
    logic             sweep_done;
    logic [CNT_W-1:0] ones_count;
`ifdef BOOL_LUT_SIGNATURE_EN
    logic [15:0]      sig;
`endif

    modport master (
`ifdef BOOL_LUT_SIGNATURE_EN
        input  sig,
`endif
        output cfg_valid, cfg_data, in_valid, in_vec, sweep_start,
        input  cfg_ready, in_ready, y_valid, y, sweep_busy, sweep_done, ones_count
    );

    modport slave (
`ifdef BOOL_LUT_SIGNATURE_EN
        output sig,
`endif
        input  cfg_valid, cfg_data, in_valid, in_vec, sweep_start,
        output cfg_ready, in_ready, y_valid, y, sweep_busy, sweep_done, ones_count
    );
endinterface

// File: rtl/bool_lut_eval.sv
// Programmable N_IN-input boolean function evaluator backed by a run-time
// loaded truth table. Supports 1-cycle registered evaluation and an
// autonomous sweep over all 2^N_IN input vectors that reports the minterm
// count (and, with BOOL_LUT_SIGNATURE_EN defined, a 16-bit MISR signature).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : bool_lut_eval_if.slave (cfg load, evaluate, sweep control/status)
module bool_lut_eval #(
    parameter int unsigned N_IN = 4
) (
    input  logic               clk,
    input  logic               rst,
    bool_lut_eval_if.slave     bus
);
    localparam int unsigned TT_W  = 1 << N_IN;
    localparam int unsigned CNT_W = N_IN + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [TT_W-1:0]  lut_q;
    logic [N_IN-1:0]  index_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_d;
    logic [CNT_W-1:0] ones_count_q;
    logic             y_q;
    logic             y_valid_q;
    logic             sweep_busy_q;
    logic             sweep_done_q;
    logic             last_index;
    logic [15:0]      sig_q;
    logic [15:0]      sig_d;

    // Per-sweep-cycle next values: running minterm total and MISR step
    always_comb begin
        acc_d      = acc_q + CNT_W'(lut_q[index_q]);
        sig_d      = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ lut_q[index_q]) ? 16'h1021 : 16'h0000);
        last_index = (index_q == {N_IN{1'b1}});
    end

    // Control FSM with all datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lut_q        <= '0;
            index_q      <= '0;
            acc_q        <= '0;
            ones_count_q <= '0;
            y_q          <= 1'b0;
            y_valid_q    <= 1'b0;
            sweep_busy_q <= 1'b0;
            sweep_done_q <= 1'b0;
            sig_q        <= 16'h0000;
        end else begin
            y_valid_q    <= 1'b0;
            sweep_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Evaluation uses the table as it stands before any same-cycle load
                    if (bus.in_valid) begin
                        y_q       <= lut_q[bus.in_vec];
                        y_valid_q <= 1'b1;
                    end
                    // A load pre-empts a same-cycle sweep request
                    if (bus.cfg_valid) begin
                        lut_q <= bus.cfg_data;
                    end else if (bus.sweep_start) begin
                        state_q      <= ST_SWEEP;
                        sweep_busy_q <= 1'b1;
                        index_q      <= '0;
                        acc_q        <= '0;
                        sig_q        <= 16'hFFFF;
                    end
                end
                ST_SWEEP: begin
                    acc_q   <= acc_d;
                    sig_q   <= sig_d;
                    index_q <= index_q + N_IN'(1);
                    // Index wraps to 0 on the same edge the sweep finishes
                    if (last_index) begin
                        state_q      <= ST_DONE;
                        sweep_busy_q <= 1'b0;
                        sweep_done_q <= 1'b1;
                        ones_count_q <= acc_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready  = (state_q == ST_IDLE);
    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.y          = y_q;
    assign bus.y_valid    = y_valid_q;
    assign bus.sweep_busy = sweep_busy_q;
    assign bus.sweep_done = sweep_done_q;
    assign bus.ones_count = ones_count_q;
`ifdef BOOL_LUT_SIGNATURE_EN
    assign bus.sig        = sig_q;
`endif

endmodule

// File: tb/tb_bool_lut_eval.sv
// Self-checking bench for bool_lut_eval (N_IN = 4): directed scenarios plus
// randomized tables/vectors checked against a truth-table reference model.
module tb_bool_lut_eval;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;
    logic [15:0] model_lut;
    logic [4:0]  model_ones;

    bool_lut_eval_if #(.N_IN(4)) bus ();

    bool_lut_eval #(.N_IN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Minterm count straight from the truth table
    function automatic int count_ones(input logic [15:0] t);
        int n = 0;
        for (int i = 0; i < 16; i++) if (t[i]) n++;
        return n;
    endfunction

    // Signature expected after walking the table from vector 0 to 15
    function automatic logic [15:0] misr_model(input logic [15:0] t);
        logic [15:0] s = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (s[15] ^ t[i]) s = {s[14:0], 1'b0} ^ 16'h1021;
            else              s = {s[14:0], 1'b0};
        end
        return s;
    endfunction

    task automatic load(input logic [15:0] t);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = t;
        tick();
        bus.cfg_valid = 1'b0;
        model_lut     = t;
    endtask

    task automatic eval(input string tag, input logic [3:0] v);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_yv"}, 32'(bus.y_valid), 32'd1);
        chk({tag, "_y"},  32'(bus.y), 32'(model_lut[v]));
        tick();
        chk({tag, "_yv_pulse"}, 32'(bus.y_valid), 32'd0);
        chk({tag, "_y_hold"},   32'(bus.y), 32'(model_lut[v]));
    endtask

    // Full sweep; optionally with a same-cycle evaluate and/or in_valid held throughout
    task automatic run_sweep(input string tag, input bit eval_too, input logic [3:0] v, input bit hold_in);
        int busy_n  = 0;
        int yv_n    = 0;
        int ready_n = 0;
        bus.sweep_start = 1'b1;
        if (eval_too) begin
            bus.in_valid = 1'b1;
            bus.in_vec   = v;
        end
        tick();
        bus.sweep_start = 1'b0;
        bus.in_valid    = hold_in;
        if (eval_too) begin
            chk({tag, "_co_yv"}, 32'(bus.y_valid), 32'd1);
            chk({tag, "_co_y"},  32'(bus.y), 32'(model_lut[v]));
        end
        for (int i = 0; i < 16; i++) begin
            if (bus.sweep_busy) busy_n++;
            if (bus.y_valid && !(eval_too && i == 0)) yv_n++;
            if (bus.cfg_ready || bus.in_ready) ready_n++;
            if (bus.sweep_done) yv_n++;
            tick();
        end
        bus.in_valid = 1'b0;
        model_ones   = 5'(count_ones(model_lut));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
        chk({tag, "_stray_out"},   32'(yv_n), 32'd0);
        chk({tag, "_ready_low"},   32'(ready_n), 32'd0);
        chk({tag, "_done"},        32'(bus.sweep_done), 32'd1);
        chk({tag, "_busy_off"},    32'(bus.sweep_busy), 32'd0);
        chk({tag, "_ones"},        32'(bus.ones_count), 32'(model_ones));
`ifdef BOOL_LUT_SIGNATURE_EN
        chk({tag, "_sig"},         32'(bus.sig), 32'(misr_model(model_lut)));
`endif
        chk({tag, "_cfg_rdy_done"}, 32'(bus.cfg_ready), 32'd0);
        tick();
        chk({tag, "_done_pulse"},  32'(bus.sweep_done), 32'd0);
        chk({tag, "_cfg_rdy"},     32'(bus.cfg_ready), 32'd1);
        chk({tag, "_in_rdy"},      32'(bus.in_ready), 32'd1);
        chk({tag, "_ones_hold"},   32'(bus.ones_count), 32'(model_ones));
    endtask

    initial begin
        logic [15:0] t;
        logic [15:0] sig_a;
        vectors = 0;
        errors  = 0;
        model_lut  = 16'h0000;
        model_ones = 5'd0;
        rst             = 1'b1;
        bus.cfg_valid   = 1'b0;
        bus.cfg_data    = 16'h0000;
        bus.in_valid    = 1'b0;
        bus.in_vec      = 4'h0;
        bus.sweep_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_cfg_ready", 32'(bus.cfg_ready),  32'd1);
        chk("rst_y",         32'(bus.y),          32'd0);
        chk("rst_y_valid",   32'(bus.y_valid),    32'd0);
        chk("rst_busy",      32'(bus.sweep_busy), 32'd0);
        chk("rst_done",      32'(bus.sweep_done), 32'd0);
        chk("rst_ones",      32'(bus.ones_count), 32'd0);
`ifdef BOOL_LUT_SIGNATURE_EN
        chk("rst_sig",       32'(bus.sig),        32'h0000);
`endif

        // Sweep of the reset (all-zero) table
        run_sweep("sw_zero", 1'b0, 4'h0, 1'b0);
`ifdef BOOL_LUT_SIGNATURE_EN
        sig_a = bus.sig;
`else
        sig_a = 16'h0000;
`endif

        // Two-minterm table
        load(16'h8001);
        run_sweep("sw_8001", 1'b0, 4'h0, 1'b0);
`ifdef BOOL_LUT_SIGNATURE_EN
        chk("sig_differs", 32'(bus.sig != sig_a), 32'd1);
`endif

        // Directed evaluation
        load(16'hF0F0);
        chk("ones_hold_load", 32'(bus.ones_count), 32'd2);
        eval("ev_4", 4'h4);
        eval("ev_8", 4'h8);

        // Load pre-empts a same-cycle sweep request
        bus.cfg_valid   = 1'b1;
        bus.cfg_data    = 16'hFFFF;
        bus.sweep_start = 1'b1;
        tick();
        bus.cfg_valid   = 1'b0;
        bus.sweep_start = 1'b0;
        model_lut       = 16'hFFFF;
        chk("prio_no_busy", 32'(bus.sweep_busy), 32'd0);
        chk("prio_ready",   32'(bus.cfg_ready),  32'd1);
        tick();
        chk("prio_no_busy2", 32'(bus.sweep_busy), 32'd0);
        run_sweep("sw_ffff", 1'b0, 4'h0, 1'b0);

        // Evaluate and sweep accepted together, evaluation on current table
        load(16'h1234);
        run_sweep("sw_coev", 1'b1, 4'h2, 1'b0);

        // Randomized tables: evaluations and sweeps against the model
        for (int r = 0; r < 6; r++) begin
            t = 16'($urandom);
            load(t);
            for (int k = 0; k < 4; k++) eval("rnd_ev", 4'($urandom_range(0, 15)));
            run_sweep("rnd_sw", 1'b0, 4'h0, 1'b0);
        end

        // Reset mid-sweep with in_valid held: no outputs, everything cleared
        load(16'hFFFF);
        bus.sweep_start = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_vec      = 4'h3;
        begin
            int yv_n = 0;
            for (int i = 0; i < 5; i++) begin
                if (bus.y_valid) yv_n++;
                tick();
            end
            chk("abort_no_yv", 32'(yv_n), 32'd0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_lut    = 16'h0000;
        chk("abort_done",  32'(bus.sweep_done), 32'd0);
        chk("abort_busy",  32'(bus.sweep_busy), 32'd0);
        chk("abort_ones",  32'(bus.ones_count), 32'd0);
        chk("abort_ready", 32'(bus.cfg_ready),  32'd1);
        tick();
        chk("abort_done2", 32'(bus.sweep_done), 32'd0);
        eval("post_abort_ev", 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
